// File: rtl/bcd_xs3_seq_conv_if.sv
// Handshake bundle for the sequential BCD <-> Excess-3 converter.
// Define BCD_XS3_PARITY_EN to add the per-digit out_par signal.
interface bcd_xs3_seq_conv_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [4*DIGITS-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_data;
    logic [DIGITS-1:0]     out_err;
    logic                  busy;
`ifdef BCD_XS3_PARITY_EN
    logic [DIGITS-1:0]     out_par;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err, busy, out_par
    );
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err, busy, out_par
    );
`else
    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err, busy
    );
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err, busy
    );
`endif
endinterface

// File: rtl/bcd_xs3_seq_conv.sv
// Multi-digit BCD <-> Excess-3 converter, one nibble per clock, LSD first.
// Define BCD_XS3_PARITY_EN to add even parity per converted digit (out_par).
module bcd_xs3_seq_conv #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_xs3_seq_conv_if.slave     bus
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [W-1:0]      data_q;
    logic              mode_q;
    logic [W-1:0]      out_data_q;
    logic [DIGITS-1:0] out_err_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              busy_q;
`ifdef BCD_XS3_PARITY_EN
    logic [DIGITS-1:0] out_par_q;
`endif

    logic [3:0] cur_nib;
    logic [3:0] conv_nib;
    logic       conv_err;

    always_comb begin
        cur_nib  = data_q[4*int'(idx_q) +: 4];
        conv_nib = 4'h0;
        conv_err = 1'b0;
        if (!mode_q) begin
            if (cur_nib <= 4'd9) conv_nib = cur_nib + 4'd3;
            else                 conv_err = 1'b1;
        end else begin
            if (cur_nib >= 4'd3 && cur_nib <= 4'd12) conv_nib = cur_nib - 4'd3;
            else                                     conv_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            data_q      <= '0;
            mode_q      <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BCD_XS3_PARITY_EN
            out_par_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    // in_ready comes up one edge after reset release
                    if (!in_ready_q) begin
                        in_ready_q <= 1'b1;
                    end else if (bus.in_valid) begin
                        data_q     <= bus.in_data;
                        mode_q     <= bus.in_mode;
                        out_data_q <= '0;
                        out_err_q  <= '0;
`ifdef BCD_XS3_PARITY_EN
                        out_par_q  <= '0;
`endif
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StConv;
                    end
                end
                StConv: begin
                    out_data_q[4*int'(idx_q) +: 4] <= conv_nib;
                    out_err_q[idx_q]               <= conv_err;
`ifdef BCD_XS3_PARITY_EN
                    out_par_q[idx_q]               <= ^conv_nib;
`endif
                    if (idx_q == LastIdx) begin
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = busy_q;
`ifdef BCD_XS3_PARITY_EN
    assign bus.out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_bcd_xs3_seq_conv.sv
// Self-checking bench for bcd_xs3_seq_conv with a result scoreboard.
// Parity checks are compiled in when BCD_XS3_PARITY_EN is defined.
module tb_bcd_xs3_seq_conv;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bcd_xs3_seq_conv_if #(.DIGITS(DIGITS)) bus ();

    bcd_xs3_seq_conv #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0]      data;
        logic [DIGITS-1:0] err;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] d, input logic m);
        exp_t       r;
        logic [3:0] n;
        logic       ok;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            n  = d[4*i +: 4];
            ok = m ? (n >= 4'd3 && n <= 4'd12) : (n <= 4'd9);
            r.data[4*i +: 4] = ok ? (m ? n - 4'd3 : n + 4'd3) : 4'h0;
            r.err[i] = !ok;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] par_of(input logic [W-1:0] d);
        logic [DIGITS-1:0] p;
        for (int i = 0; i < DIGITS; i++) p[i] = ^d[4*i +: 4];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one word for the accepting edge.
    task automatic start_word(input logic [W-1:0] d, input logic m, output bit ok);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        ok = bus.in_ready;
        bus.in_data  = d;
        bus.in_mode  = m;
        bus.in_valid = ok;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic take_out(output logic [W-1:0] d, output logic [DIGITS-1:0] e,
                            output logic [DIGITS-1:0] p);
        d = bus.out_data;
        e = bus.out_err;
`ifdef BCD_XS3_PARITY_EN
        p = bus.out_par;
`else
        p = par_of(bus.out_data);
`endif
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b ready=%b busy=%b required 0 0 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        checks++;
        if (bus.out_data !== '0 || bus.out_err !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h/%b required 0/0", bus.out_data, bus.out_err);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b required 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_convert();
        logic [W-1:0]      din [3] = '{16'h1234, 16'h4567, 16'hC3B3};
        logic              mds [3] = '{1'b0, 1'b1, 1'b1};
        logic [W-1:0]      dexp[3] = '{16'h4567, 16'h1234, 16'h9080};
        logic [W-1:0]      d;
        logic [DIGITS-1:0] e, p;
        exp_t              x;
        int                lat;
        bit                ok;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{data: dexp[i], err: '0});
            start_word(din[i], mds[i], ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL convert_accept[%0d]: got in_ready=0 required 1", i);
            end
            wait_out(lat);
            checks++;
            if (lat != DIGITS) begin
                errors++;
                $display("FAIL convert_latency[%0d]: got %0d required %0d", i, lat, DIGITS);
            end
            take_out(d, e, p);
            x = sb.pop_front();
            checks++;
            if (d !== x.data || e !== x.err) begin
                errors++;
                $display("FAIL convert[%0d]: got %h/%b required %h/%b", i, d, e, x.data, x.err);
            end
            checks++;
            if (p !== par_of(x.data)) begin
                errors++;
                $display("FAIL convert_par[%0d]: got %b required %b", i, p, par_of(x.data));
            end
        end
    endtask

    task automatic test_invalid();
        logic [W-1:0]      d;
        logic [DIGITS-1:0] e, p;
        exp_t              x;
        int                lat;
        bit                ok;
        sb.push_back('{data: 16'h30C8, err: 4'b0100});
        start_word(16'h0A95, 1'b0, ok);
        wait_out(lat);
        take_out(d, e, p);
        x = sb.pop_front();
        checks++;
        if (!ok || d !== x.data || e !== x.err) begin
            errors++;
            $display("FAIL invalid: got %h/%b required %h/%b", d, e, x.data, x.err);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]      d;
        logic [DIGITS-1:0] e, p;
        exp_t              x;
        int                lat;
        bit                ok;
        sb.push_back('{data: 16'h30C8, err: 4'b0100});
        start_word(16'h0A95, 1'b0, ok);
        wait_out(lat);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h9999;
        bus.in_mode  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_data !== 16'h30C8 || bus.out_err !== 4'b0100) begin
                errors++;
                $display("FAIL hold[%0d]: got v=%b r=%b %h/%b required 1 0 30c8/0100",
                         c, bus.out_valid, bus.in_ready, bus.out_data, bus.out_err);
            end
        end
        bus.in_valid = 1'b0;
        take_out(d, e, p);
        x = sb.pop_front();
        checks++;
        if (d !== x.data || e !== x.err) begin
            errors++;
            $display("FAIL bp_data: got %h/%b required %h/%b", d, e, x.data, x.err);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: got r=%b v=%b b=%b required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        sb.push_back('{data: 16'h4567, err: '0});
        start_word(16'h1234, 1'b0, ok);
        wait_out(lat);
        take_out(d, e, p);
        x = sb.pop_front();
        checks++;
        if (!ok || lat != DIGITS || d !== x.data || e !== x.err) begin
            errors++;
            $display("FAIL bp_next: got %h/%b lat=%0d required %h/%b lat=%0d",
                     d, e, lat, x.data, x.err, DIGITS);
        end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0]      d;
        logic [DIGITS-1:0] e, p;
        exp_t              x;
        int                lat;
        bit                ok;
        sb.push_back('{data: 16'h4567, err: '0});
        start_word(16'h1234, 1'b0, ok);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_data !== '0 || bus.out_err !== '0) begin
            errors++;
            $display("FAIL abort: got v=%b r=%b b=%b %h/%b required 0 0 0 0/0",
                     bus.out_valid, bus.in_ready, bus.busy, bus.out_data, bus.out_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        sb.push_back('{data: 16'h4567, err: '0});
        start_word(16'h1234, 1'b0, ok);
        wait_out(lat);
        take_out(d, e, p);
        x = sb.pop_front();
        checks++;
        if (!ok || lat != DIGITS || d !== x.data || e !== x.err) begin
            errors++;
            $display("FAIL post_abort: got %h/%b lat=%0d required %h/%b", d, e, lat,
                     x.data, x.err);
        end
`ifdef BCD_XS3_PARITY_EN
        checks++;
        if (p !== 4'b1001) begin
            errors++;
            $display("FAIL par_1234: got %b required 1001", p);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]      d, din;
        logic [DIGITS-1:0] e, p;
        logic              m;
        exp_t              x;
        int                lat;
        bit                ok;
        for (int i = 0; i < 16; i++) begin
            din = W'($urandom);
            m   = 1'($urandom_range(0, 1));
            sb.push_back(model(din, m));
            start_word(din, m, ok);
            wait_out(lat);
            repeat ($urandom_range(0, 2)) tick();
            take_out(d, e, p);
            x = sb.pop_front();
            checks++;
            if (!ok || lat != DIGITS || d !== x.data || e !== x.err) begin
                errors++;
                $display("FAIL rand[%0d] in=%h m=%b: got %h/%b lat=%0d required %h/%b",
                         i, din, m, d, e, lat, x.data, x.err);
            end
            checks++;
            if (p !== par_of(x.data)) begin
                errors++;
                $display("FAIL rand_par[%0d]: got %b required %b", i, p, par_of(x.data));
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_convert();
        test_invalid();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
